// File: rtl/accum_core.sv
// accum_core: parametrised accumulator CPU core with a FETCH/EXEC/MEMRD sequencer.
// Define ACCUM_CORE_HALT_EN to make opcode 0 a HALT; without it opcode 0 is a NOP.
module accum_core #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [ADDR_W+3:0] imem_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_re,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] in_port,
  output logic [DATA_W-1:0] out_port,
  output logic              out_strobe,
  output logic [ADDR_W-1:0] pc_o,
  output logic [DATA_W-1:0] acc_o,
  output logic              carry,
  output logic              zero,
  output logic              exec_phase,
  output logic              halted
);

`ifdef ACCUM_CORE_HALT_EN
  typedef enum logic [1:0] {FETCH, EXEC, MEMRD, HALT} state_e;
`else
  typedef enum logic [1:0] {FETCH, EXEC, MEMRD} state_e;
`endif

  typedef enum logic [3:0] {
    OP_NOP, OP_LDI, OP_LD, OP_ST, OP_ADDI, OP_ADD, OP_SUBI, OP_SUB,
    OP_CMPI, OP_NANDI, OP_IN, OP_OUT, OP_JMP, OP_JC, OP_JNC, OP_JZ
  } opcode_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W+3:0] instr_q, instr_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] outPort_q, outPort_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;

  opcode_e           opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] aluB;
  logic [DATA_W-1:0] nandRes;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic              reqRaw, reRaw, weRaw, strobeRaw;

  assign opcode  = opcode_e'(instr_q[ADDR_W+3:ADDR_W]);
  assign operand = instr_q[ADDR_W-1:0];
  // Second ALU operand: the immediate during EXEC, the RAM word during MEMRD.
  assign aluB    = (state_q == MEMRD) ? ram_rdata : operand[DATA_W-1:0];
  assign sum     = {1'b0, acc_q} + {1'b0, aluB};
  assign diff    = {1'b0, acc_q} - {1'b0, aluB};
  assign nandRes = ~(acc_q & aluB);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    outPort_d = outPort_q;
    reqRaw    = 1'b0;
    reRaw     = 1'b0;
    weRaw     = 1'b0;
    strobeRaw = 1'b0;
    case (state_q)
      FETCH: begin
        reqRaw = 1'b1;
        if (imem_valid) begin
          instr_d = imem_rdata;
          pc_d    = pc_q + ADDR_W'(1);
          state_d = EXEC;
        end
      end
      EXEC: begin
        state_d = FETCH;
        case (opcode)
          OP_NOP: begin
`ifdef ACCUM_CORE_HALT_EN
            state_d = HALT;
`endif
          end
          OP_LDI: begin
            acc_d  = aluB;
            zero_d = (aluB == '0);
          end
          OP_LD, OP_ADD, OP_SUB: begin
            reRaw   = 1'b1;
            state_d = MEMRD;
          end
          OP_ST: weRaw = 1'b1;
          OP_ADDI: begin
            acc_d   = sum[DATA_W-1:0];
            carry_d = sum[DATA_W];
            zero_d  = (sum[DATA_W-1:0] == '0);
          end
          OP_SUBI: begin
            acc_d   = diff[DATA_W-1:0];
            carry_d = ~diff[DATA_W];
            zero_d  = (diff[DATA_W-1:0] == '0);
          end
          OP_CMPI: begin
            carry_d = ~diff[DATA_W];
            zero_d  = (diff[DATA_W-1:0] == '0);
          end
          OP_NANDI: begin
            acc_d  = nandRes;
            zero_d = (nandRes == '0);
          end
          OP_IN: begin
            acc_d  = in_port;
            zero_d = (in_port == '0);
          end
          OP_OUT: begin
            outPort_d = acc_q;
            strobeRaw = 1'b1;
          end
          // Jumps test the flags as they stood before this instruction.
          OP_JMP: pc_d = operand;
          OP_JC:  if (carry_q)  pc_d = operand;
          OP_JNC: if (!carry_q) pc_d = operand;
          OP_JZ:  if (zero_q)   pc_d = operand;
          default: ;
        endcase
      end
      MEMRD: begin
        state_d = FETCH;
        case (opcode)
          OP_ADD: begin
            acc_d   = sum[DATA_W-1:0];
            carry_d = sum[DATA_W];
            zero_d  = (sum[DATA_W-1:0] == '0);
          end
          OP_SUB: begin
            acc_d   = diff[DATA_W-1:0];
            carry_d = ~diff[DATA_W];
            zero_d  = (diff[DATA_W-1:0] == '0);
          end
          default: begin
            acc_d  = ram_rdata;
            zero_d = (ram_rdata == '0);
          end
        endcase
      end
`ifdef ACCUM_CORE_HALT_EN
      HALT: ;
`endif
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= '0;
      instr_q   <= '0;
      acc_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      outPort_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      acc_q     <= acc_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      outPort_q <= outPort_d;
    end
  end

  // Strobes are masked by reset so an instruction caught by reset has no side effects.
  assign imem_req   = reqRaw & ~reset;
  assign ram_re     = reRaw & ~reset;
  assign ram_we     = weRaw & ~reset;
  assign out_strobe = strobeRaw & ~reset;
  assign exec_phase = ~reset & ((state_q == EXEC) || (state_q == MEMRD));
  assign imem_addr  = pc_q;
  assign ram_addr   = operand;
  assign ram_wdata  = acc_q;
  assign out_port   = outPort_q;
  assign pc_o       = pc_q;
  assign acc_o      = acc_q;
  assign carry      = carry_q;
  assign zero       = zero_q;

`ifdef ACCUM_CORE_HALT_EN
  assign halted = ~reset & (state_q == HALT);
`else
  assign halted = 1'b0;
`endif

endmodule

// File: tb/tb_accum_core.sv
// tb_accum_core: table-driven, corner-case and random checks of accum_core
// against an arithmetic reference model of the instruction set.
module tb_accum_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imemReq;
  logic [11:0] imemAddr;
  logic        imemValid = 1'b0;
  logic [15:0] imemRdata = '0;
  logic [11:0] ramAddr;
  logic        ramRe;
  logic [3:0]  ramRdata;
  logic        ramWe;
  logic [3:0]  ramWdata;
  logic [3:0]  inPort = '0;
  logic [3:0]  outPort;
  logic        outStrobe;
  logic [11:0] pcO;
  logic [3:0]  accO;
  logic        carry, zero, execPhase, halted;

  int checks = 0;
  int errors = 0;

  int refPc, refAcc, refCarry, refZero, refOut;
  int refMem [4096];
  bit [3:0] tbMem [4096];

  typedef struct {
    int op; int operand; int waitCyc; int inVal;
    int expAcc; int expCarry; int expZero; int expPc; int expOut;
  } vec_t;
  vec_t vecs [29];

  accum_core #(.DATA_W(4), .ADDR_W(12)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imemReq), .imem_addr(imemAddr), .imem_valid(imemValid), .imem_rdata(imemRdata),
    .ram_addr(ramAddr), .ram_re(ramRe), .ram_rdata(ramRdata), .ram_we(ramWe), .ram_wdata(ramWdata),
    .in_port(inPort), .out_port(outPort), .out_strobe(outStrobe),
    .pc_o(pcO), .acc_o(accO), .carry(carry), .zero(zero),
    .exec_phase(execPhase), .halted(halted)
  );

  always #5 clk = ~clk;

  // Synchronous data RAM seen by the core: one-cycle read latency.
  always @(posedge clk) begin
    if (ramWe) tbMem[ramAddr] <= ramWdata;
    if (ramRe) ramRdata <= tbMem[ramAddr];
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic resetModel();
    refPc = 0; refAcc = 0; refCarry = 0; refZero = 0; refOut = 0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    imemValid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstReq", imemReq, 0);
    checkOutput("rstWe", ramWe, 0);
    checkOutput("rstRe", ramRe, 0);
    checkOutput("rstStrobe", outStrobe, 0);
    checkOutput("rstHalted", halted, 0);
    reset = 1'b0;
    resetModel();
    #1;
    checkOutput("relReq", imemReq, 1);
    checkOutput("relAddr", imemAddr, 0);
    checkOutput("relAcc", accO, 0);
    checkOutput("relCarry", carry, 0);
    checkOutput("relZero", zero, 0);
    checkOutput("relOut", outPort, 0);
    checkOutput("relPhase", execPhase, 0);
  endtask

  // Runs one instruction from FETCH back to FETCH, starting and ending at #1 after an edge.
  task automatic applyStimulus(input int op, input int operand, input int waitCyc, input int inVal);
    int imm, rd, b, r;
    bit isMem;
    imm = operand % 16;
    isMem = (op == 2 || op == 5 || op == 7);
    inPort = inVal[3:0];
    for (int w = 0; w < waitCyc; w++) begin
      imemValid = 1'b0;
      imemRdata = 16'($urandom);
      checkOutput("waitAddr", imemAddr, refPc);
      checkOutput("waitReq", imemReq, 1);
      checkOutput("waitPhase", execPhase, 0);
      checkOutput("waitAcc", accO, refAcc);
      checkOutput("waitFlags", {carry, zero}, {refCarry[0], refZero[0]});
      @(posedge clk); #1;
    end
    checkOutput("fetchAddr", imemAddr, refPc);
    checkOutput("fetchReq", imemReq, 1);
    imemValid = 1'b1;
    imemRdata = {op[3:0], operand[11:0]};
    @(posedge clk); #1;
    imemValid = 1'b0;
    imemRdata = 16'($urandom);
    refPc = (refPc + 1) % 4096;
    checkOutput("execPhase", execPhase, 1);
    checkOutput("execPc", pcO, refPc);
    checkOutput("execReq", imemReq, 0);
    checkOutput("execRamRe", ramRe, isMem);
    checkOutput("execRamWe", ramWe, op == 3);
    checkOutput("execStrobe", outStrobe, op == 11);
    if (isMem || op == 3) checkOutput("execRamAddr", ramAddr, operand);
    if (op == 3) checkOutput("execRamWdata", ramWdata, refAcc);
`ifdef ACCUM_CORE_HALT_EN
    if (op == 0) begin
      @(posedge clk); #1;
      for (int h = 0; h < 3; h++) begin
        imemValid = 1'b1;
        checkOutput("haltFlag", halted, 1);
        checkOutput("haltReq", imemReq, 0);
        checkOutput("haltPc", pcO, refPc);
        checkOutput("haltAcc", accO, refAcc);
        @(posedge clk); #1;
      end
      imemValid = 1'b0;
      return;
    end
`endif
    if (isMem) begin
      @(posedge clk); #1;
      checkOutput("memrdPhase", execPhase, 1);
      checkOutput("memrdRe", ramRe, 0);
    end
    rd = refMem[operand];
    b = (op == 5 || op == 7) ? rd : imm;
    case (op)
      1:  refAcc = imm;
      2:  refAcc = rd;
      3:  refMem[operand] = refAcc;
      4, 5: begin
        r = refAcc + b;
        refCarry = (r >= 16) ? 1 : 0;
        refAcc = r % 16;
      end
      6, 7: begin
        refCarry = (refAcc >= b) ? 1 : 0;
        refAcc = (refAcc - b + 16) % 16;
      end
      8: begin
        refCarry = (refAcc >= imm) ? 1 : 0;
        refZero = (refAcc == imm) ? 1 : 0;
      end
      9:  refAcc = 15 - (refAcc & imm);
      10: refAcc = inVal % 16;
      11: refOut = refAcc;
      12: refPc = operand;
      13: if (refCarry == 1) refPc = operand;
      14: if (refCarry == 0) refPc = operand;
      15: if (refZero == 1) refPc = operand;
      default: ;
    endcase
    if (op == 1 || op == 2 || (op >= 4 && op <= 7) || op == 9 || op == 10)
      refZero = (refAcc == 0) ? 1 : 0;
    @(posedge clk); #1;
    checkOutput("donePhase", execPhase, 0);
    checkOutput("doneReq", imemReq, 1);
    checkOutput("donePc", pcO, refPc);
    checkOutput("doneAddr", imemAddr, refPc);
    checkOutput("doneAcc", accO, refAcc);
    checkOutput("doneCarry", carry, refCarry);
    checkOutput("doneZero", zero, refZero);
    checkOutput("doneOut", outPort, refOut);
    checkOutput("doneHalted", halted, 0);
  endtask

  initial begin
    // op, operand, wait, in, acc, carry, zero, pc, out
    vecs[0]  = '{1,  'h00A, 0, 0,   'hA, 0, 0, 'h001, 0};
    vecs[1]  = '{4,  'h007, 0, 0,   'h1, 1, 0, 'h002, 0};
    vecs[2]  = '{1,  'h005, 0, 0,   'h5, 1, 0, 'h003, 0};
    vecs[3]  = '{6,  'h005, 3, 0,   'h0, 1, 1, 'h004, 0};
    vecs[4]  = '{6,  'h001, 0, 0,   'hF, 0, 0, 'h005, 0};
    vecs[5]  = '{8,  'h00F, 0, 0,   'hF, 1, 1, 'h006, 0};
    vecs[6]  = '{15, 'h123, 0, 0,   'hF, 1, 1, 'h123, 0};
    vecs[7]  = '{9,  'h000, 1, 0,   'hF, 1, 0, 'h124, 0};
    vecs[8]  = '{15, 'h200, 0, 0,   'hF, 1, 0, 'h125, 0};
    vecs[9]  = '{13, 'h300, 0, 0,   'hF, 1, 0, 'h300, 0};
    vecs[10] = '{14, 'h400, 0, 0,   'hF, 1, 0, 'h301, 0};
    vecs[11] = '{1,  'h009, 0, 0,   'h9, 1, 0, 'h302, 0};
    vecs[12] = '{3,  'h005, 0, 0,   'h9, 1, 0, 'h303, 0};
    vecs[13] = '{1,  'h000, 0, 0,   'h0, 1, 1, 'h304, 0};
    vecs[14] = '{2,  'h005, 0, 0,   'h9, 1, 0, 'h305, 0};
    vecs[15] = '{5,  'h005, 0, 0,   'h2, 1, 0, 'h306, 0};
    vecs[16] = '{7,  'h005, 0, 0,   'h9, 0, 0, 'h307, 0};
    vecs[17] = '{10, 'h000, 0, 0,   'h0, 0, 1, 'h308, 0};
    vecs[18] = '{14, 'hFFF, 0, 0,   'h0, 0, 1, 'hFFF, 0};
`ifdef ACCUM_CORE_HALT_EN
    vecs[19] = '{4,  'h000, 0, 0,   'h0, 0, 1, 'h000, 0};
`else
    vecs[19] = '{0,  'h000, 0, 0,   'h0, 0, 1, 'h000, 0};
`endif
    vecs[20] = '{1,  'h006, 0, 0,   'h6, 0, 0, 'h001, 0};
    vecs[21] = '{11, 'h000, 0, 0,   'h6, 0, 0, 'h002, 6};
    vecs[22] = '{10, 'h000, 0, 'hC, 'hC, 0, 0, 'h003, 6};
    vecs[23] = '{12, 'hFFF, 0, 0,   'hC, 0, 0, 'hFFF, 6};
    vecs[24] = '{9,  'h006, 0, 0,   'hB, 0, 0, 'h000, 6};
    vecs[25] = '{4,  'hFF5, 0, 0,   'h0, 1, 1, 'h001, 6};
    vecs[26] = '{8,  'h001, 0, 0,   'h0, 0, 0, 'h002, 6};
    vecs[27] = '{13, 'h050, 0, 0,   'h0, 0, 0, 'h003, 6};
    vecs[28] = '{14, 'h050, 0, 0,   'h0, 0, 0, 'h050, 6};

    resetModel();
    doReset();

    for (int i = 0; i < 29; i++) begin
      applyStimulus(vecs[i].op, vecs[i].operand, vecs[i].waitCyc, vecs[i].inVal);
      checkOutput($sformatf("tblAcc[%0d]", i), accO, vecs[i].expAcc);
      checkOutput($sformatf("tblCarry[%0d]", i), carry, vecs[i].expCarry);
      checkOutput($sformatf("tblZero[%0d]", i), zero, vecs[i].expZero);
      checkOutput($sformatf("tblPc[%0d]", i), imemAddr, vecs[i].expPc);
      checkOutput($sformatf("tblOut[%0d]", i), outPort, vecs[i].expOut);
    end

    // Reset landing on an ST in EXEC must suppress the RAM write.
    applyStimulus(1, 'h00B, 0, 0);
    imemValid = 1'b1;
    imemRdata = {4'd3, 12'h007};
    @(posedge clk); #1;
    imemValid = 1'b0;
    checkOutput("preRstWe", ramWe, 1);
    reset = 1'b1;
    #1;
    checkOutput("midRstWe", ramWe, 0);
    checkOutput("midRstReq", imemReq, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    resetModel();
    #1;
    applyStimulus(2, 'h007, 0, 0);
    checkOutput("abandonedSt", accO, 0);

    // Reset landing on an OUT in EXEC must suppress the strobe and the latch update.
    applyStimulus(1, 'h00D, 0, 0);
    imemValid = 1'b1;
    imemRdata = {4'd11, 12'h000};
    @(posedge clk); #1;
    imemValid = 1'b0;
    checkOutput("preRstStrobe", outStrobe, 1);
    reset = 1'b1;
    #1;
    checkOutput("midRstStrobe", outStrobe, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    resetModel();
    #1;
    checkOutput("abandonedOut", outPort, 0);

    for (int n = 0; n < 300; n++) begin
      int op;
      int opnd;
      op = int'($urandom_range(0, 15));
`ifdef ACCUM_CORE_HALT_EN
      if (op == 0) op = 1;
`endif
      opnd = int'($urandom_range(0, 4095));
      if (op == 2 || op == 3 || op == 5 || op == 7) opnd = int'($urandom_range(0, 15));
      applyStimulus(op, opnd, int'($urandom_range(0, 2)), int'($urandom_range(0, 15)));
    end

    // Opcode 0: HALT when enabled, otherwise a NOP that falls through to pc+1.
    applyStimulus(0, 'h010, 1, 0);
    doReset();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/accum_core.md
# accum_core

Parametrised accumulator CPU core, the next generation of the Nibbler 4-bit machine: configurable data and address widths, working jumps, a handshaked instruction-fetch port, a synchronous data-RAM port, and active-high flags. It executes one instruction per FETCH/EXEC cycle, plus a MEMRD cycle for RAM-sourced operands. It sits between the program memory, the data RAM and the I/O pins at the top of the design.

## Interface
- DATA_W, 4, accumulator/ALU/RAM data width; must satisfy 1 ≤ DATA_W ≤ ADDR_W
- ADDR_W, 12, program and data address width; instruction width is ADDR_W+4
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  fetch request, high only in FETCH
- imem_addr  out  ADDR_W  fetch address (= pc)
- imem_valid  in  1  instruction word valid; sampled only in FETCH
- imem_rdata  in  ADDR_W+4  instruction: [ADDR_W+3:ADDR_W] opcode, [ADDR_W-1:0] operand
- ram_addr  out  ADDR_W  data address (= operand)
- ram_re  out  1  read strobe; ram_rdata is valid the following cycle
- ram_rdata  in  DATA_W  read data
- ram_we  out  1  write strobe, one cycle
- ram_wdata  out  DATA_W  write data (= acc)
- in_port  in  DATA_W  input pins
- out_port  out  DATA_W  registered output latch
- out_strobe  out  1  one-cycle pulse when out_port is written
- pc_o, acc_o  out  ADDR_W, DATA_W  debug views
- carry, zero  out  1  flags, active-high
- exec_phase  out  1  high in EXEC and MEMRD
- halted  out  1  high in HALT

## Operation
- States: FETCH, EXEC, MEMRD, HALT.
- FETCH: imem_req=1, imem_addr=pc. On imem_valid: latch instr, pc←pc+1 (mod 2^ADDR_W), go to EXEC. Otherwise hold; imem_addr stays stable.
- imm = operand[DATA_W-1:0]. Opcodes:
  - 0 NOP
  - 1 LDI: A←imm
  - 2 LD: A←RAM
  - 3 ST: RAM←A
  - 4 ADDI / 5 ADD: A←A+imm / A+RAM
  - 6 SUBI / 7 SUB: A←A−imm / A−RAM
  - 8 CMPI: A−imm, flags only
  - 9 NANDI: A←~(A&imm)
  - 10 IN: A←in_port
  - 11 OUT: out_port←A, out_strobe=1
  - 12 JMP / 13 JC / 14 JNC / 15 JZ: pc←operand if the condition holds
- EXEC: single-cycle ops complete, then FETCH. LD/ADD/SUB assert ram_re with ram_addr=operand and go to MEMRD. MEMRD uses ram_rdata, then FETCH. ST asserts ram_we for exactly one cycle in EXEC.
- Arithmetic is DATA_W+1 wide. Add: carry = bit DATA_W. Subtract/compare: carry=1 iff no borrow (A ≥ operand). Results truncate to DATA_W.
- zero = (result==0) for every A-writing op and CMPI. carry changes only on add/sub/CMPI; other ops preserve it.
- Jumps, NOP, ST and OUT leave the flags unchanged.
- A jump is evaluated against the flags as they stood before the jump. A taken jump overrides the already-incremented pc.

## Timing
- Reset values: pc=0, acc=0, carry=0, zero=0, out_port=0, state=FETCH; out_strobe, ram_re, ram_we and halted are 0.
- imem_req=0 while reset is high, and 1 in the first cycle after reset.
- Zero-wait fetch (imem_valid in the first FETCH cycle) gives 2 cycles per instruction, or 3 for LD/ADD/SUB. Each wait cycle adds one.
- Reset mid-operation abandons the instruction: no RAM write, no out_strobe. The program memory must drop any pending response on the same reset.
- A write to pc takes effect on the next imem_addr. pc wraps 2^ADDR_W−1 → 0.

## Configuration
- ACCUM_CORE_HALT_EN defined: opcode 0 is HALT. EXEC enters HALT, where halted=1 and imem_req=0, and the core holds all state until reset.
- ACCUM_CORE_HALT_EN undefined: opcode 0 is NOP, the HALT state does not exist, and halted is tied to 0.

## Test plan
All scenarios use DATA_W=4, ADDR_W=12.
- Reset, then release → imem_req=1, imem_addr=0x000, acc=0, carry=0, zero=0.
- LDI 0xA (0x100A), ADDI 0x7 (0x4007) → acc=0x1, carry=1, zero=0.
- acc=5, SUBI 5 → acc=0, zero=1, carry=1. Then SUBI 1 → acc=0xF, carry=0, zero=0.
- Hold imem_valid low for 3 cycles in FETCH → imem_addr constant, pc/acc/flags unchanged, exec_phase=0.
- zero=1, JZ 0x123 → next imem_addr=0x123. With zero=0 → pc+1. JMP 0xFFF, then NOP → next imem_addr=0x000.
- acc=9, ST 0x005 → one-cycle ram_we with ram_addr=5, ram_wdata=9. Then LD 0x005 with ram_rdata=9 → acc=9 after MEMRD, zero=0.
- Opcode 0x0 with the macro defined → halted=1 and imem_req=0 permanently. Without the macro → next fetch from pc+1.
